ncl_add_sequencer: RTL and testbench

NCL_ADD_SEQUENCER -- requirements
Module: ncl_add_sequencer

---
 rtl/ncl_add_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ncl_add_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_add_sequencer.sv
// ncl_add_sequencer: clocked four-phase handshake sequencer for a dual-rail
// NCL ripple-carry adder. It presents the operands as DATA and waits for the
// datapath to accept them. It captures the completed dual-rail result, then
// returns the datapath to NULL and pulses done. A per-phase watchdog parks the
// block in ST_ERR if the datapath stalls.
// Optional macro NCL_SEQ_ILLEGAL_CHK_EN: a synchronized result pair with both
// rails high in ST_CAPT or ST_NULL forces ST_ERR on the next edge. Without the
// macro, such a pair simply counts as incomplete.
module ncl_add_sequencer #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 op_cin,
  output logic [2*WIDTH-1:0]   a_dr,
  output logic [2*WIDTH-1:0]   b_dr,
  output logic [1:0]           cin_dr,
  input  logic                 in_comp,
  input  logic [2*WIDTH-1:0]   sum_dr,
  input  logic [1:0]           cout_dr,
  output logic                 sum_comp,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH:0]       result,
  output logic                 err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DATA, ST_CAPT, ST_NULL, ST_DONE, ST_ERR
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 load;
  logic                 ops_live;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 cin_q;

  // Two-flop synchronizer stages for the asynchronous datapath signals.
  // The result pairs are kept as one vector with the carry pair on top.
  logic                 in_comp_p0, in_comp_p1;
  logic [2*WIDTH+1:0]   res_p0, res_p1;

  logic                 res_complete;
  logic                 res_null;

  // Dual-rail encode: rail0 (false) at 2i, rail1 (true) at 2i+1.
  function automatic logic [2*WIDTH-1:0] dr_encode(input logic [WIDTH-1:0] x);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i]   = ~x[i];
      r[2*i+1] = x[i];
    end
    return r;
  endfunction

  // A pair is complete when exactly one rail is high; 2'b11 is not complete.
  function automatic logic dr_complete(input logic [2*WIDTH+1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i <= WIDTH; i++) ok &= v[2*i] ^ v[2*i+1];
    return ok;
  endfunction

  // Decoded bit is the true rail qualified by a low false rail.
  function automatic logic [WIDTH:0] dr_decode(input logic [2*WIDTH+1:0] v);
    logic [WIDTH:0] r;
    r = '0;
    for (int i = 0; i <= WIDTH; i++) r[i] = v[2*i+1] & ~v[2*i];
    return r;
  endfunction

`ifdef NCL_SEQ_ILLEGAL_CHK_EN
  logic res_illegal;

  function automatic logic dr_illegal(input logic [2*WIDTH+1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i <= WIDTH; i++) bad |= v[2*i] & v[2*i+1];
    return bad;
  endfunction

  assign res_illegal = dr_illegal(res_p1);
`endif

  assign res_complete = dr_complete(res_p1);
  assign res_null     = (res_p1 == '0);

  // Synchronize completion and result rails into the clk domain.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      in_comp_p0 <= 1'b0;
      in_comp_p1 <= 1'b0;
      res_p0     <= '0;
      res_p1     <= '0;
    end else begin
      in_comp_p0 <= in_comp;
      in_comp_p1 <= in_comp_p0;
      res_p0     <= {cout_dr, sum_dr};
      res_p1     <= res_p0;
    end
  end

  // Operand capture on an accepted start; only meaningful while rails are live.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      a_q   <= op_a;
      b_q   <= op_b;
      cin_q <= op_cin;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge init) begin
    if (init) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; load marks the CAPT->NULL edge where the result is taken.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (in_comp_p1)             state_nxt = ST_CAPT;
        else if (cnt == CNT_LAST)   state_nxt = ST_ERR;
      end
      ST_CAPT: begin
        if (res_complete) begin
          state_nxt = ST_NULL;
          load      = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_ERR;
        end
`ifdef NCL_SEQ_ILLEGAL_CHK_EN
        if (res_illegal) begin
          state_nxt = ST_ERR;
          load      = 1'b0;
        end
`endif
      end
      ST_NULL: begin
        if (!in_comp_p1 && res_null) state_nxt = ST_DONE;
        else if (cnt == CNT_LAST)    state_nxt = ST_ERR;
`ifdef NCL_SEQ_ILLEGAL_CHK_EN
        if (res_illegal) state_nxt = ST_ERR;
`endif
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase watchdog: restarts on every state change, counts in handshake phases.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == ST_DATA || state == ST_CAPT || state == ST_NULL) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Result register: loads only on a clean capture, otherwise holds.
  always_ff @(posedge clk or posedge init) begin
    if (init)      result <= '0;
    else if (load) result <= dr_decode(res_p1);
  end

  // Outputs decoded from the state so that init clears them immediately.
  assign ops_live = (state == ST_DATA) || (state == ST_CAPT);
  assign a_dr     = ops_live ? dr_encode(a_q) : '0;
  assign b_dr     = ops_live ? dr_encode(b_q) : '0;
  assign cin_dr   = ops_live ? {cin_q, ~cin_q} : 2'b00;
  assign sum_comp = (state == ST_NULL) || (state == ST_ERR);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERR);

endmodule

// File: tb/tb_ncl_add_sequencer.sv
// Scoreboard bench for ncl_add_sequencer with a behavioural dual-rail adder
// datapath that answers the handshake after a random delay.
`timescale 1ns/1ps
module tb_ncl_add_sequencer;
  localparam int W  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           init, start;
  logic [W-1:0]   op_a, op_b;
  logic           op_cin;
  logic [2*W-1:0] a_dr, b_dr;
  logic [1:0]     cin_dr;
  logic           in_comp;
  logic [2*W-1:0] sum_dr;
  logic [1:0]     cout_dr;
  logic           sum_comp, busy, done, err;
  logic [W:0]     result;

  int         checks = 0;
  int         errors = 0;
  logic [W:0] exp_q[$];
  int         done_cnt = 0;
  int         ops_cnt  = 0;
  logic [W:0] last_res = '0;
  bit         mode_nocomp  = 1'b0;
  bit         mode_illegal = 1'b0;
  bit         model_rst    = 1'b1;
  int         dly     = 0;
  int         dly_max = 2;
  bit         busy_chk = 1'b0;

  ncl_add_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .init(init), .start(start),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .a_dr(a_dr), .b_dr(b_dr), .cin_dr(cin_dr),
    .in_comp(in_comp), .sum_dr(sum_dr), .cout_dr(cout_dr),
    .sum_comp(sum_comp), .busy(busy), .done(done),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] x);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[2*i+1 -: 2] = x[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic is_data(input logic [2*W-1:0] v);
    for (int i = 0; i < W; i++) if (v[2*i] == v[2*i+1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] dec(input logic [2*W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[2*i+1];
    return r;
  endfunction

  // Datapath model: DATA operands with sum_comp low -> DATA result and
  // in_comp high; NULL operands -> in_comp low, and NULL result once
  // sum_comp is high. Each change is applied after a random delay.
  always @(negedge clk) begin
    logic           w_comp;
    logic [2*W-1:0] w_sum;
    logic [1:0]     w_cout;
    int             s;
    if (model_rst) begin
      in_comp = 1'b0; sum_dr = '0; cout_dr = 2'b00; dly = 0;
    end else begin
      w_comp = in_comp; w_sum = sum_dr; w_cout = cout_dr;
      if (is_data(a_dr) && is_data(b_dr) && (cin_dr[0] != cin_dr[1])) begin
        w_comp = !mode_nocomp;
        if (!sum_comp && !mode_nocomp) begin
          s = int'(dec(a_dr)) + int'(dec(b_dr)) + int'(cin_dr[1]);
          w_sum  = enc(W'(s));
          w_cout = s[W] ? 2'b10 : 2'b01;
          if (mode_illegal) w_sum[1:0] = 2'b11;
        end
      end else if (a_dr == '0 && b_dr == '0 && cin_dr == 2'b00) begin
        w_comp = 1'b0;
        if (sum_comp) begin w_sum = '0; w_cout = 2'b00; end
      end
      if ({w_comp, w_sum, w_cout} != {in_comp, sum_dr, cout_dr}) begin
        if (dly == 0) begin
          in_comp = w_comp; sum_dr = w_sum; cout_dr = w_cout;
          dly = int'($urandom_range(0, dly_max));
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (busy_chk) begin
      busy_chk = 1'b0;
      check("busy_after_done", 64'(busy), 64'(0));
      check("done_single_pulse", 64'(done), 64'(0));
    end
    if (init == 1'b0 && done == 1'b1) begin
      done_cnt++;
      check("scoreboard_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) check("result", 64'(result), 64'(exp_q.pop_front()));
      busy_chk = 1'b1;
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit extra);
    int n;
    logic [W:0] e;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    e = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    op_a = a; op_b = b; op_cin = c; start = 1'b1;
    exp_q.push_back(e);
    ops_cnt++;
    last_res = e;
    @(negedge clk);
    start = 1'b0;
    op_a = ~a; op_b = ~b; op_cin = ~c;
    check("data_a_dr", 64'(a_dr), 64'(enc(a)));
    check("data_b_dr", 64'(b_dr), 64'(enc(b)));
    check("data_cin_dr", 64'(cin_dr), 64'(c ? 2'b10 : 2'b01));
    if (extra) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check("done_within_bound", 64'(n < 100), 64'(1));
    @(negedge clk);
  endtask

  task automatic do_init();
    #1 init = 1'b1; model_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("init_clears_err", 64'(err), 64'(0));
    check("init_clears_busy", 64'(busy), 64'(0));
    init = 1'b0; model_rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    init = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_sum_comp", 64'(sum_comp), 64'(0));
    check("rst_rails", 64'({a_dr, b_dr, cin_dr}), 64'(0));
    init = 1'b0; model_rst = 1'b0;
    @(negedge clk);

    run_op(4'd5, 4'd9, 1'b0, 1'b0);
    run_op(4'd15, 4'd1, 1'b1, 1'b0);
    run_op(4'd0, 4'd0, 1'b0, 1'b0);
    run_op(4'd15, 4'd15, 1'b1, 1'b0);
    run_op(4'd3, 4'd4, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    // init while the sequencer sits in the NULL phase
    op_a = 4'd6; op_b = 4'd7; op_cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!sum_comp && n < 50) begin @(negedge clk); n++; end
    check("reach_null", 64'(n < 50), 64'(1));
    #1 init = 1'b1; model_rst = 1'b1;
    #1;
    check("init_null_rails", 64'({a_dr, b_dr, cin_dr}), 64'(0));
    check("init_null_busy", 64'(busy), 64'(0));
    check("init_null_sum_comp", 64'(sum_comp), 64'(0));
    check("init_null_result", 64'(result), 64'(0));
    repeat (2) @(negedge clk);
    init = 1'b0; model_rst = 1'b0;
    @(negedge clk);
    run_op(4'd6, 4'd7, 1'b1, 1'b0);

    // datapath never accepts: watchdog in the DATA phase
    mode_nocomp = 1'b1;
    op_a = 4'd2; op_b = 4'd3; op_cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!err && n < 40) begin n++; @(negedge clk); end
    check("timeout_data_cycles", 64'(n), 64'(TO));
    check("err_flag", 64'(err), 64'(1));
    check("err_rails", 64'({a_dr, b_dr, cin_dr}), 64'(0));
    check("err_sum_comp", 64'(sum_comp), 64'(1));
    check("err_busy", 64'(busy), 64'(1));
    check("err_result_held", 64'(result), 64'(last_res));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(err), 64'(1));
    check("err_sticky_sum_comp", 64'(sum_comp), 64'(1));
    mode_nocomp = 1'b0;
    do_init();

    // both rails high on result pair 0 during capture
    dly_max = 0; mode_illegal = 1'b1;
    op_a = 4'd1; op_b = 4'd2; op_cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!err && n < 40) begin n++; @(negedge clk); end
`ifdef NCL_SEQ_ILLEGAL_CHK_EN
    check("illegal_pair_to_err", 64'(n), 64'(4));
`else
    check("illegal_pair_waits_timeout", 64'(n), 64'(3 + TO));
`endif
    check("illegal_err_flag", 64'(err), 64'(1));
    mode_illegal = 1'b0;
    do_init();
    dly_max = 2;

    for (int i = 0; i < 5; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("done_count", 64'(done_cnt), 64'(ops_cnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
